wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback stage directly upstream of the register file. It merges results from two producers onto the register file's single write port (rd_write/rd/rd_data):
- ALU: single-cycle results.
- MEM: load or long-latency results.

It arbitrates between them round-robin and keeps a per-register busy scoreboard. The scoreboard lets issue logic stall on RAW hazards until the register file holds the new value.

Parameters:
XLEN, 64, width of result data and rd_data
NREG, 32, architectural register count; fixed, matches the 5-bit register address

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  MEM result valid
mem_ready  out  1  MEM result accepted this cycle
mem_rd  in  5  MEM destination register
mem_data  in  XLEN  MEM result
issue_valid  in  1  an instruction writing issue_rd issues this cycle
issue_rd  in  5  destination of the issuing instruction
rs1  in  5  source register 1 being checked
rs2  in  5  source register 2 being checked
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
busy  out  NREG  full scoreboard vector
rd_write  out  1  register file write enable
rd  out  5  register file write address
rd_data  out  XLEN  register file write data

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rd_write=0, rd=0, rd_data=0, busy=0.
  - last_grant=MEM, so the first tie goes to ALU.
  - alu_ready=0 and mem_ready=0 while rst_n=0; in-flight producer results are dropped.
- Arbitration (combinational ready):
  - Only one source valid: that source is granted.
  - Both valid: grant the source not equal to last_grant.
  - Neither valid: no grant.
  - x_ready=1 iff x is granted; at most one ready is high per cycle.
  - last_grant updates on every accept (valid&&ready), including accepts with rd==0.
  - A non-granted valid source must hold its rd/data stable until accepted.
- Output register, 1-cycle latency:
  - On accept at edge N: rd/rd_data take the winner's rd/data; rd_write = (winner rd != 0).
  - Without an accept: rd_write=0; rd/rd_data hold their previous values.
  - rd_write is high for exactly one cycle per accepted nonzero-rd result.
  - Throughput is one result per cycle.
- Scoreboard:
  - busy[0] is constantly 0.
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd] at the next edge.
  - Clear: busy[rd] clears at the same edge where the register file captures the write (rd_write=1).
  - Set and clear of the same register at the same edge: set wins (the new pending write).
  - rs1_busy = busy[rs1], rs2_busy = busy[rs2]; both combinational and 0 for x0.
  - Consequence: busy drops in the cycle after rd_write, when the register file read already returns the new value. There is no bypass.
- Illegal conditions (simulation assertions, no RTL recovery):
  - Issue to a register that is already busy with no clear at the same edge (WAW not supported).
  - Accepting a result whose nonzero rd is not busy.

Decomposition:
- Package wb_pkg holds:
  - XLEN, NREG, REG_AW=5.
  - typedef wb_req_t {rd[4:0], data[XLEN-1:0]}.
  - enum grant_e {GNT_ALU, GNT_MEM}.
- One natural sub-module, wb_scoreboard: the busy vector with set/clear/priority and the two read ports. The arbiter and output register stay in wb_arbiter.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → rd_write=0, busy=0, both readys 0 during reset.
- Single ALU result: issue x5; next cycle alu_valid, rd=5, data=0xDEAD → alu_ready=1; next cycle rd_write=1, rd=5, rd_data=0xDEAD; busy[5] set until that edge; rs1=5 gives rs1_busy=0 one cycle after rd_write.
- Tie round-robin: issue x1, x2; then hold alu(rd=1, 0x11) and mem(rd=2, 0x22) valid together → ALU granted first, MEM second; rd_write on consecutive cycles with rd 1 then 2.
- Back-to-back streaming: MEM only, 4 consecutive results to x3, x4, x6, x7 → mem_ready high 4 cycles; rd_write high 4 consecutive cycles in order.
- x0 result and simultaneous set/clear: alu rd=0 → accepted, rd_write stays 0, busy unchanged. Separately, rd_write to x9 at the same edge as issue_rd=9 → busy[9] remains 1.
- Mid-operation reset: both sources valid and busy=0x0000_00F0, assert rst_n=0 for one cycle → next cycle busy=0, rd_write=0; readys 0 during reset; the first post-reset tie is granted to ALU.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its scoreboard.
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    // One producer result headed for the register file write port.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Which producer won the most recent accept; drives the round-robin tie-break.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard. A bit is set when an instruction
// writing that register issues and cleared when the register file captures
// the write. x0 never goes busy.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_valid_i,
    input  logic [REG_AW-1:0] set_rd_i,
    input  logic              clr_valid_i,
    input  logic [REG_AW-1:0] clr_rd_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: clear first so a same-edge set of the same register wins.
    always_comb begin
        // NOTE: busy_d starts from the held value so every path assigns it and no latch is inferred.
        busy_d = busy_q;
        if (clr_valid_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_valid_i) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the busy vector is state issue logic reads directly, so unlike a data RAM it must be reset.
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block ordering.
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];
    assign busy_o     = busy_q;

    // Issuing to a register that already has a pending write (and is not
    // being retired at the same edge) would lose track of one of the writes.
    a_no_waw: assert property (@(posedge clk) disable iff (!rst_n)
        !(set_valid_i && (set_rd_i != '0) && busy_q[set_rd_i] &&
          !(clr_valid_i && (clr_rd_i == set_rd_i))));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin merge of ALU and MEM results onto the single
// register file write port through a one-cycle output register, plus the
// busy scoreboard that issue logic uses to stall on RAW hazards.
module wb_arbiter #(
    parameter int XLEN = wb_pkg::XLEN,  // must match wb_pkg::XLEN (wb_req_t width)
    parameter int NREG = wb_pkg::NREG   // fixed by the 5-bit register address
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [wb_pkg::REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [wb_pkg::REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]           mem_data,
    input  logic                      issue_valid,
    input  logic [wb_pkg::REG_AW-1:0] issue_rd,
    input  logic [wb_pkg::REG_AW-1:0] rs1,
    input  logic [wb_pkg::REG_AW-1:0] rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [NREG-1:0]           busy,
    output logic                      rd_write,
    output logic [wb_pkg::REG_AW-1:0] rd,
    output logic [XLEN-1:0]           rd_data
);

    import wb_pkg::*;

    wb_req_t           alu_req;
    wb_req_t           mem_req;
    wb_req_t           win_req;
    logic              alu_gnt;
    logic              mem_gnt;
    logic              accept;

    grant_e            last_grant_q;
    grant_e            last_grant_d;
    logic              rd_write_q;
    logic              rd_write_d;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rd_d;
    logic [XLEN-1:0]   rd_data_q;
    logic [XLEN-1:0]   rd_data_d;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign mem_req = '{rd: mem_rd, data: mem_data};

    // Round-robin grant: a lone valid source wins; on a tie the source that
    // was not served last wins. Nothing is granted while reset is asserted.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (rst_n) begin
            if (alu_valid && mem_valid) begin
                if (last_grant_q == GNT_MEM) begin
                    alu_gnt = 1'b1;
                end else begin
                    mem_gnt = 1'b1;
                end
            end else begin
                alu_gnt = alu_valid;
                mem_gnt = mem_valid;
            end
        end
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;
    assign accept    = alu_gnt || mem_gnt;
    assign win_req   = alu_gnt ? alu_req : mem_req;

    // Next-state for the output register and the round-robin pointer. rd and
    // rd_data follow every accept (even x0); the write strobe only fires for
    // a real destination.
    always_comb begin
        last_grant_d = last_grant_q;
        rd_d         = rd_q;
        rd_data_d    = rd_data_q;
        rd_write_d   = 1'b0;
        if (accept) begin
            last_grant_d = alu_gnt ? GNT_ALU : GNT_MEM;
            rd_d         = win_req.rd;
            rd_data_d    = win_req.data;
            rd_write_d   = (win_req.rd != '0);
        end
    end

    // Output register and grant history; reset leaves MEM as last winner so
    // the first tie goes to the ALU.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GNT_MEM;
            rd_write_q   <= 1'b0;
            rd_q         <= '0;
            rd_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_write_q   <= rd_write_d;
            rd_q         <= rd_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_write = rd_write_q;
    assign rd       = rd_q;
    assign rd_data  = rd_data_q;

    // The scoreboard retires a register at the same edge the register file
    // captures it, so the busy bit drops once the file already holds the value.
    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (issue_valid),
        .set_rd_i    (issue_rd),
        .clr_valid_i (rd_write_q),
        .clr_rd_i    (rd_q),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rs1_busy_o  (rs1_busy),
        .rs2_busy_o  (rs2_busy),
        .busy_o      (busy)
    );

    // A result for a real register must have been announced at issue.
    a_accept_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && (win_req.rd != '0) && !busy[win_req.rd]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the writeback rules.
module tb_wb_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, mem_valid, issue_valid;
    logic            alu_ready, mem_ready;
    logic [4:0]      alu_rd, mem_rd, issue_rd, rs1, rs2;
    logic [XLEN-1:0] alu_data, mem_data;
    logic            rs1_busy, rs2_busy, rd_write;
    logic [31:0]     busy;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;

    wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .busy        (busy),
        .rd_write    (rd_write),
        .rd          (rd),
        .rd_data     (rd_data)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } item_t;

    item_t q_alu[$];
    item_t q_mem[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: pending registers, who was served last, and
    // what the register file write port shows after the last edge.
    logic [31:0]     m_busy;
    logic            m_last_mem;
    logic            m_wr;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    logic            acc_alu_last, acc_mem_last;

    int stream_rd[4] = '{3, 4, 6, 7};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A source is served when it is the only one asking, or on a tie when
    // the other source was served last.
    function automatic logic exp_alu_rdy();
        return rst_n && alu_valid && (!mem_valid || m_last_mem);
    endfunction

    function automatic logic exp_mem_rdy();
        return rst_n && mem_valid && (!alu_valid || !m_last_mem);
    endfunction

    task automatic model_reset();
        m_busy     = '0;
        m_last_mem = 1'b1;
        m_wr       = 1'b0;
        m_rd       = '0;
        m_data     = '0;
    endtask

    task automatic model_update();
        acc_alu_last = exp_alu_rdy();
        acc_mem_last = exp_mem_rdy();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_wr) m_busy[m_rd] = 1'b0;
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            if (acc_alu_last) begin
                m_rd = alu_rd; m_data = alu_data; m_wr = (alu_rd != 5'd0); m_last_mem = 1'b0;
            end else if (acc_mem_last) begin
                m_rd = mem_rd; m_data = mem_data; m_wr = (mem_rd != 5'd0); m_last_mem = 1'b1;
            end else begin
                m_wr = 1'b0;
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are compared just after,
    // then the model advances across the rising edge.
    task automatic step();
        #1;
        check("alu_ready", 64'(alu_ready), 64'(exp_alu_rdy()));
        check("mem_ready", 64'(mem_ready), 64'(exp_mem_rdy()));
        check("rd_write",  64'(rd_write),  64'(m_wr));
        check("rd",        64'(rd),        64'(m_rd));
        check("rd_data",   rd_data,        m_data);
        check("busy",      64'(busy),      64'(m_busy));
        check("rs1_busy",  64'(rs1_busy),  64'(m_busy[rs1]));
        check("rs2_busy",  64'(rs2_busy),  64'(m_busy[rs2]));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic issue(input logic [4:0] r);
        issue_valid = 1'b1; issue_rd = r;
        step();
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    initial begin
        item_t it;
        item_t pend;
        logic  have_pend;
        int    guard;

        drive_idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with both producers asking: nothing may be accepted.
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h1;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 64'h2;
        #1;
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_rd_write",  64'(rd_write),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        step();
        step();
        rst_n = 1'b1;
        drive_idle();
        step();

        // Single ALU result to x5.
        issue(5'd5);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD; rs1 = 5'd5;
        #1;
        check("alu1_ready", 64'(alu_ready), 64'd1);
        check("alu1_busy5", 64'(busy[5]), 64'd1);
        step();
        alu_valid = 1'b0;
        #1;
        check("alu1_wr",      64'(rd_write), 64'd1);
        check("alu1_rd",      64'(rd),       64'd5);
        check("alu1_data",    rd_data,       64'hDEAD);
        check("alu1_rs1busy", 64'(rs1_busy), 64'd1);
        step();
        #1;
        check("alu1_rs1free", 64'(rs1_busy), 64'd0);
        check("alu1_wr_once", 64'(rd_write), 64'd0);
        rs1 = '0;
        step();

        // MEM streaming, one result per cycle.
        for (int i = 0; i < 4; i++) issue(5'(stream_rd[i]));
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1; mem_rd = 5'(stream_rd[k]); mem_data = 64'h300 + 64'(k);
            #1;
            check("strm_ready", 64'(mem_ready), 64'd1);
            if (k > 0) begin
                check("strm_wr", 64'(rd_write), 64'd1);
                check("strm_rd", 64'(rd), 64'(stream_rd[k-1]));
            end
            step();
        end
        mem_valid = 1'b0;
        #1;
        check("strm_wr_last", 64'(rd_write), 64'd1);
        check("strm_rd_last", 64'(rd), 64'd7);
        step();
        step();

        // Tie after a MEM accept: ALU first, then MEM.
        issue(5'd1);
        issue(5'd2);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h22;
        #1;
        check("tie_alu_ready", 64'(alu_ready), 64'd1);
        check("tie_mem_wait",  64'(mem_ready), 64'd0);
        step();
        alu_valid = 1'b0;
        #1;
        check("tie_mem_ready", 64'(mem_ready), 64'd1);
        check("tie_rd_first",  64'(rd),        64'd1);
        check("tie_data_first", rd_data,       64'h11);
        step();
        mem_valid = 1'b0;
        #1;
        check("tie_wr_second", 64'(rd_write), 64'd1);
        check("tie_rd_second", 64'(rd),       64'd2);
        check("tie_data_second", rd_data,     64'h22);
        step();
        step();

        // x0 result: accepted but never written.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h55;
        #1;
        check("x0_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        #1;
        check("x0_no_write", 64'(rd_write), 64'd0);
        check("x0_busy",     64'(busy),     64'd0);
        step();

        // Write of x9 coincides with a new issue of x9: stays busy.
        issue(5'd9);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        step();
        alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        check("x9_wr", 64'(rd_write), 64'd1);
        check("x9_rd", 64'(rd),       64'd9);
        step();
        issue_valid = 1'b0; issue_rd = '0;
        #1;
        check("x9_set_wins", 64'(busy[9]), 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h9A;
        step();
        alu_valid = 1'b0;
        step();
        #1;
        check("x9_cleared", 64'(busy[9]), 64'd0);
        step();

        // Reset in the middle of traffic.
        for (int r = 4; r < 8; r++) issue(5'(r));
        #1;
        check("mid_busy_f0", 64'(busy), 64'h0000_00F0);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hA4;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 64'hB5;
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu", 64'(alu_ready), 64'd0);
        check("mid_rst_mem", 64'(mem_ready), 64'd0);
        step();
        rst_n = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check("mid_busy_clr", 64'(busy),     64'd0);
        check("mid_wr_clr",   64'(rd_write), 64'd0);
        step();
        issue(5'd4);
        issue(5'd5);
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        check("mid_tie_alu", 64'(alu_ready), 64'd1);
        check("mid_tie_mem", 64'(mem_ready), 64'd0);
        step();
        alu_valid = 1'b0;
        step();
        mem_valid = 1'b0;
        step();
        step();

        // Random traffic: issues to free registers, results queued behind them.
        drive_idle();
        have_pend = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!alu_valid && q_alu.size() > 0 && ($urandom % 4) != 0) begin
                alu_valid = 1'b1; alu_rd = q_alu[0].rd; alu_data = q_alu[0].data;
            end
            if (!mem_valid && q_mem.size() > 0 && ($urandom % 4) != 0) begin
                mem_valid = 1'b1; mem_rd = q_mem[0].rd; mem_data = q_mem[0].data;
            end
            issue_valid = 1'b0; issue_rd = 5'($urandom);
            if (($urandom % 2) == 0) begin
                it.rd = 5'($urandom_range(1, 31));
                if (!m_busy[it.rd]) begin
                    issue_valid = 1'b1; issue_rd = it.rd;
                    it.data = {$urandom, $urandom};
                    pend = it; have_pend = 1'b1;
                end
            end
            if (($urandom % 16) == 0) begin
                it.rd = 5'd0; it.data = {$urandom, $urandom};
                if ($urandom % 2) q_alu.push_back(it); else q_mem.push_back(it);
            end
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            step();
            if (acc_alu_last) begin void'(q_alu.pop_front()); alu_valid = 1'b0; end
            if (acc_mem_last) begin void'(q_mem.pop_front()); mem_valid = 1'b0; end
            if (have_pend) begin
                if ($urandom % 2) q_alu.push_back(pend); else q_mem.push_back(pend);
                have_pend = 1'b0;
            end
        end

        // Drain whatever is still queued, within a bounded number of cycles.
        issue_valid = 1'b0;
        guard = 0;
        while ((q_alu.size() > 0 || q_mem.size() > 0) && guard < 400) begin
            if (!alu_valid && q_alu.size() > 0) begin
                alu_valid = 1'b1; alu_rd = q_alu[0].rd; alu_data = q_alu[0].data;
            end
            if (!mem_valid && q_mem.size() > 0) begin
                mem_valid = 1'b1; mem_rd = q_mem[0].rd; mem_data = q_mem[0].data;
            end
            step();
            if (acc_alu_last) begin void'(q_alu.pop_front()); alu_valid = 1'b0; end
            if (acc_mem_last) begin void'(q_mem.pop_front()); mem_valid = 1'b0; end
            guard++;
        end
        check("drain_left", 64'(q_alu.size() + q_mem.size()), 64'd0);
        drive_idle();
        step();
        step();
        #1;
        check("final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
